// File: rtl/force_result_capture_pkg.sv
// Shared MD pipeline definitions: capture FSM encoding and default geometry of a result bank.
package force_result_capture_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 10000;
  localparam int DEF_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/force_capture_bank.sv
// Simple dual-port result RAM, one write port and one registered read port on a single clock.
// A read and a write to the same address in one cycle return the previously stored word.
module force_capture_bank #(
  parameter int WIDTH      = 96,
  parameter int DEPTH      = 10000,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset; callers only enable ports for in-range addresses.
  always_ff @(posedge clk) begin
    if (we) mem[IDX_W'(waddr)] <= wdata;
    if (re) rdata <= mem[IDX_W'(raddr)];
  end

endmodule

// File: rtl/force_result_capture.sv
// Captures per-channel force results of one pipeline run into per-channel banks and
// serves readback of the stored {z,y,x} words; reports run status.
module force_result_capture
  import force_result_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 1,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CYC_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ctrl_start,
  output logic                               pipe_start,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       force_x,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       force_y,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       force_z,
  input  logic [NUM_CH-1:0]                  force_valid,
  input  logic [NUM_CH-1:0]                  pipe_done,
  input  logic                               rd_en,
  input  logic [CH_WIDTH-1:0]                rd_ch,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [3*DATA_WIDTH-1:0]            rd_data,
  output logic                               rd_valid,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   wr_count,
  output logic [NUM_CH-1:0]                  overflow,
  output logic                               busy,
  output logic                               done,
  output logic [CYC_WIDTH-1:0]               cycle_count,
  output logic [1:0]                         dbg_state
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW3 = 3 * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  cap_state_e          state;
  logic                ctrl_prev;
  logic                rise;
  logic [NUM_CH-1:0]   done_flags;
  logic [CW-1:0]       cnt [NUM_CH];
  logic [NUM_CH-1:0]   bank_we;
  logic [NUM_CH-1:0]   bank_re;
  logic [DW3-1:0]      bank_q [NUM_CH];
  logic                rd_hit;
  logic                rd_hit_q;
  logic [CH_WIDTH-1:0] rd_ch_q;

  assign rise      = ctrl_start & ~ctrl_prev;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // ctrl_prev resets high so a start level already present at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ctrl_prev   <= 1'b1;
      pipe_start  <= 1'b0;
      done_flags  <= '0;
      overflow    <= '0;
      cycle_count <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      ctrl_prev  <= ctrl_start;
      pipe_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (rise) begin
            state       <= ST_RUN;
            pipe_start  <= 1'b1;
            done_flags  <= '0;
            overflow    <= '0;
            cycle_count <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
          end
        end
        ST_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          done_flags <= done_flags | pipe_done;
          for (int c = 0; c < NUM_CH; c++) begin
            if (force_valid[c]) begin
              if (bank_we[c]) cnt[c] <= cnt[c] + 1'b1;
              else            overflow[c] <= 1'b1;
            end
          end
          // Leave on the cycle after the last done flag has been registered.
          if (&done_flags) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Readback: rd_en is a request with no backpressure; rd_valid answers it exactly one cycle later.
  assign rd_hit = ({1'b0, rd_ch} < (CH_WIDTH+1)'(NUM_CH)) &&
                  ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
      rd_ch_q  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_hit_q <= rd_en && rd_hit;
      rd_ch_q  <= rd_ch;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_valid && rd_hit_q && (rd_ch_q == CH_WIDTH'(c))) rd_data = bank_q[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_count[c*CW +: CW] = cnt[c];
    assign bank_we[c] = (state == ST_RUN) && force_valid[c] && (cnt[c] < DEPTH_C);
    assign bank_re[c] = rd_en && rd_hit && (rd_ch == CH_WIDTH'(c));

    force_capture_bank #(
      .WIDTH      (DW3),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[c]),
      .waddr (cnt[c][ADDR_WIDTH-1:0]),
      .wdata ({force_z[c*DATA_WIDTH +: DATA_WIDTH],
               force_y[c*DATA_WIDTH +: DATA_WIDTH],
               force_x[c*DATA_WIDTH +: DATA_WIDTH]}),
      .re    (bank_re[c]),
      .raddr (rd_addr),
      .rdata (bank_q[c])
    );
  end

endmodule

// File: doc/force_result_capture.md
FORCE_RESULT_CAPTURE -- requirements
Module: force_result_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one force component.
REQ-002 SHALL have parameter NUM_CH, default 2, number of force pipelines captured.
REQ-003 SHALL have parameter CH_WIDTH, default 1, log2(NUM_CH), minimum 1.
REQ-004 SHALL have parameter DEPTH, default 10000, result entries per channel.
REQ-005 SHALL have parameter ADDR_WIDTH, default 14, log2(DEPTH).
REQ-006 SHALL have parameter CYC_WIDTH, default 32, width of the run cycle counter.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port ctrl_start  input  1  level from the control RAM; a rising edge requests a run.
REQ-010 SHALL have port pipe_start  output  1  one-cycle start pulse to all pipelines.
REQ-011 SHALL have port force_x, force_y, force_z  input  NUM_CH*DATA_WIDTH each  packed per-channel force components, channel 0 in the LSBs.
REQ-012 SHALL have port force_valid  input  NUM_CH  per-channel force-output valid.
REQ-013 SHALL have port pipe_done  input  NUM_CH  per-channel pipeline done.
REQ-014 SHALL have ports rd_en (1), rd_ch (CH_WIDTH) and rd_addr (ADDR_WIDTH), all inputs, forming the readback request.
REQ-015 SHALL have port rd_data  output  3*DATA_WIDTH  readback word {z,y,x}.
REQ-016 SHALL have port rd_valid  output  1  readback data qualifier.
REQ-017 SHALL have port wr_count  output  NUM_CH*(ADDR_WIDTH+1)  entries stored per channel.
REQ-018 SHALL have ports overflow (NUM_CH), busy (1), done (1) and cycle_count (CYC_WIDTH), all outputs, reporting status.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE; from DONE a new ctrl_start rising edge re-enters RUN.
REQ-020 SHALL detect the rising edge as ctrl_start=1 while the registered previous value is 0; the previous-value register resets to 1, so a level already high at reset release starts nothing.
REQ-021 SHALL, on a rising edge in IDLE or DONE, enter RUN next cycle with pipe_start=1 for exactly that one cycle, and clear wr_count, overflow, cycle_count and the sticky done flags.
REQ-022 SHALL ignore rising edges while in RUN.
REQ-023 SHALL, in RUN, write {z,y,x} of channel c to bank c at address wr_count[c] and increment wr_count[c] on every cycle force_valid[c]=1; all channels write independently in the same cycle.
REQ-024 SHALL, when wr_count[c]=DEPTH and force_valid[c]=1, drop the sample, hold wr_count[c] and set overflow[c] sticky until the next run.
REQ-025 SHALL ignore force_valid and pipe_done outside RUN.
REQ-026 SHALL latch pipe_done[c] into a sticky flag; a valid sample arriving in the same cycle as pipe_done is still captured.
REQ-027 SHALL go RUN -> DONE on the cycle after all sticky done flags are set; done=1 in DONE only; busy=1 in RUN only.
REQ-028 SHALL increment cycle_count on every RUN cycle, including the pipe_start cycle, saturating at all-ones.
REQ-029 SHALL serve readback in any state: rd_data and rd_valid appear one cycle after rd_en, and rd_valid=0 otherwise.
REQ-030 SHALL return rd_data=0 with rd_valid=1 when rd_ch>=NUM_CH or rd_addr>=DEPTH.
REQ-031 SHALL return old data when a read and a write to the same bank and address occur in the same cycle.

Reset
REQ-032 SHALL, on rst=0 at any time including mid-run, force the FSM to IDLE and drive pipe_start=0, busy=0, done=0, rd_valid=0, rd_data=0, wr_count=0, overflow=0 and cycle_count=0.
REQ-033 SHALL leave bank memory contents uninitialised and uncleared by reset.
REQ-034 SHALL exit reset synchronously on the first clk edge after rst returns to 1.

Structure
REQ-035 SHALL place the FSM state encoding and the default DATA_WIDTH, DEPTH and ADDR_WIDTH constants in the shared MD pipeline package.
REQ-036 SHALL use one sub-module, force_capture_bank: a single-clock simple dual-port RAM of 3*DATA_WIDTH by DEPTH with registered read, instantiated NUM_CH times.

Verification
REQ-037 SHALL cover: ctrl_start 0->1 -> pipe_start high for exactly 1 cycle and busy=1; holding ctrl_start high gives no second pulse.
REQ-038 SHALL cover: ch0 5 valids of x=1.0, y=2.0, z=3.0 and ch1 3 valids, then both pipe_done -> wr_count={3,5}, done=1, and reading ch0 addr 4 returns {3.0,2.0,1.0} with rd_valid one cycle later.
REQ-039 SHALL cover: DEPTH=4 with 6 valids on ch1 -> wr_count[1]=4, overflow=2'b10, and the first 4 samples intact.
REQ-040 SHALL cover: pipe_done[0] at run cycle 10 and pipe_done[1] at cycle 20 -> done asserts at cycle 21 and cycle_count=21.
REQ-041 SHALL cover: rst=0 asserted mid-run after 7 samples -> all status outputs 0 and FSM in IDLE; ctrl_start held high through reset gives no pipe_start.
REQ-042 SHALL cover: rd_ch=3 with NUM_CH=2, and rd_addr=DEPTH -> rd_data=0, rd_valid=1.
